// File: rtl/egd_pkg.sv
// Shared constants for the Exp-Golomb bitstream input buffer.
package egd_pkg;

   localparam int unsigned EGD_IN_W        = 8;
   localparam int unsigned EGD_BUF_W       = 32;
   localparam int unsigned EGD_WIN_W       = 16;
   localparam int unsigned EGD_MAX_CONSUME = 16;
   localparam int unsigned EGD_CNT_W       = 16;
   localparam int unsigned EGD_LEN_W       = 5;
   localparam int unsigned FILL_W          = $clog2(EGD_BUF_W + 1);

endpackage

// File: rtl/egd_shift_merge.sv
// Combinational next-state datapath for the bitstream buffer: optional
// barrel left-shift by shamt, then an optional byte insert directly
// below the remaining valid bits.
//   buf_q/fill     : current left-justified contents and valid-bit count
//   shamt/do_shift : bits to drop from the top (caller guarantees legality)
//   in_data/do_insert : byte to append after the shift
//   next_buf/next_fill : resulting contents and count
module egd_shift_merge
   import egd_pkg::*;
#(
   parameter int unsigned IN_W  = EGD_IN_W,
   parameter int unsigned BUF_W = EGD_BUF_W,
   parameter int unsigned FW    = $clog2(BUF_W + 1)
) (
   input  logic [BUF_W-1:0]     buf_q,
   input  logic [FW-1:0]        fill,
   input  logic [EGD_LEN_W-1:0] shamt,
   input  logic                 do_shift,
   input  logic [IN_W-1:0]      in_data,
   input  logic                 do_insert,
   output logic [BUF_W-1:0]     next_buf,
   output logic [FW-1:0]        next_fill
);

   logic [BUF_W-1:0] shifted;
   logic [FW-1:0]    fill_s;
   logic [BUF_W-1:0] ins;

   // Shift stage; vacated low bits fill with zero, keeping the invariant.
   always_comb begin
      shifted = buf_q;
      fill_s  = fill;
      if (do_shift) begin
         shifted = buf_q << shamt;
         fill_s  = fill - FW'(shamt);
      end
   end

   // Insert stage; OR is safe because everything below fill_s is zero.
   always_comb begin
      ins       = {in_data, {(BUF_W - IN_W){1'b0}}} >> fill_s;
      next_buf  = shifted;
      next_fill = fill_s;
      if (do_insert) begin
         next_buf  = shifted | ins;
         next_fill = fill_s + FW'(IN_W);
      end
   end

endmodule

// File: rtl/egd_bitstream_buffer.sv
// Bit-aligned input buffer feeding the Exp-Golomb decoder core.
// Bytes arrive MSB-first over in_valid/in_ready; the decoder sees the
// next WIN_W stream bits on win_data and removes consume_len of them.
//   clk, rst         : clock, synchronous active-high reset
//   in_data/in_valid/in_ready : byte input handshake
//   flush            : discard buffered bits (statistics kept)
//   win_data/win_valid : next WIN_W bits, valid when fill >= WIN_W
//   consume/consume_len : decoder bit-removal strobe and count
//   fill_level       : valid bits held
//   underflow_err    : sticky illegal-consume flag
//   bits_consumed    : wrapping count of removed bits
module egd_bitstream_buffer
   import egd_pkg::*;
#(
   parameter int unsigned IN_W  = EGD_IN_W,
   parameter int unsigned BUF_W = EGD_BUF_W,
   parameter int unsigned WIN_W = EGD_WIN_W,
   parameter int unsigned CNT_W = EGD_CNT_W
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [IN_W-1:0]                   in_data,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic                              flush,
   output logic [WIN_W-1:0]                  win_data,
   output logic                              win_valid,
   input  logic                              consume,
   input  logic [EGD_LEN_W-1:0]              consume_len,
   output logic [$clog2(BUF_W + 1)-1:0]      fill_level,
   output logic                              underflow_err,
   output logic [CNT_W-1:0]                  bits_consumed
);

   localparam int unsigned FW = $clog2(BUF_W + 1);

   logic [BUF_W-1:0] buf_q;
   logic [FW-1:0]    fill_q;
   logic             err_q;
   logic [CNT_W-1:0] cnt_q;

   logic             accept;
   logic             legal_consume;
   logic             illegal_consume;
   logic [BUF_W-1:0] next_buf;
   logic [FW-1:0]    next_fill;

   // Window and status are straight views of the state registers.
   assign win_data      = buf_q[BUF_W-1 -: WIN_W];
   assign win_valid     = (fill_q >= FW'(WIN_W));
   assign fill_level    = fill_q;
   assign underflow_err = err_q;
   assign bits_consumed = cnt_q;

   // Room for a whole byte means fill <= BUF_W-IN_W, so inserts never overflow.
   assign in_ready = !rst && !flush && (fill_q <= FW'(BUF_W - IN_W));
   assign accept   = in_valid && in_ready;

   assign legal_consume   = consume && win_valid && (consume_len != '0) &&
                            (consume_len <= EGD_LEN_W'(EGD_MAX_CONSUME));
   assign illegal_consume = consume && !legal_consume;

   egd_shift_merge #(
      .IN_W  (IN_W),
      .BUF_W (BUF_W),
      .FW    (FW)
   ) u_shift_merge (
      .buf_q     (buf_q),
      .fill      (fill_q),
      .shamt     (consume_len),
      .do_shift  (legal_consume),
      .in_data   (in_data),
      .do_insert (accept),
      .next_buf  (next_buf),
      .next_fill (next_fill)
   );

   // State update: reset, then flush, then shift/insert.
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_q  <= '0;
         fill_q <= '0;
         err_q  <= 1'b0;
         cnt_q  <= '0;
      end else if (flush) begin
         buf_q  <= '0;
         fill_q <= '0;
         err_q  <= 1'b0;
      end else begin
         buf_q  <= next_buf;
         fill_q <= next_fill;
         if (legal_consume) cnt_q <= cnt_q + CNT_W'(consume_len);
         if (illegal_consume) err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_egd_bitstream_buffer.sv
// Self-checking bench: a bit-queue reference model of the buffer is
// driven alongside the DUT through directed and random sequences.
module tb_egd_bitstream_buffer;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, consume;
   logic [7:0]  in_data;
   logic [4:0]  consume_len;
   logic        in_ready, win_valid, underflow_err;
   logic [15:0] win_data, bits_consumed;
   logic [5:0]  fill_level;

   always #5 clk = ~clk;

   egd_bitstream_buffer dut (
      .clk           (clk),
      .rst           (rst),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .flush         (flush),
      .win_data      (win_data),
      .win_valid     (win_valid),
      .consume       (consume),
      .consume_len   (consume_len),
      .fill_level    (fill_level),
      .underflow_err (underflow_err),
      .bits_consumed (bits_consumed)
   );

   // Reference model: the stream as a queue of bits, front = next bit.
   bit          mq[$];
   logic        err_m;
   logic [15:0] cnt_m;
   logic        last_acc;
   int          total = 0;
   int          bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] win_m();
      logic [15:0] w;
      w = '0;
      for (int i = 0; i < 16; i++)
         if (i < mq.size()) w[15-i] = mq[i];
      return w;
   endfunction

   // One clock: drive at negedge, check in_ready, advance model, check state.
   task automatic cyc(input logic r, input logic f, input logic v, input logic [7:0] d,
                      input logic c, input logic [4:0] l);
      logic exp_rdy, legal;
      rst = r; flush = f; in_valid = v; in_data = d; consume = c; consume_len = l;
      #1;
      exp_rdy = !r && !f && (mq.size() <= 24);
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      last_acc = v && exp_rdy;
      if (r) begin
         mq.delete(); err_m = 1'b0; cnt_m = '0;
      end else if (f) begin
         mq.delete(); err_m = 1'b0;
      end else begin
         legal = c && (mq.size() >= 16) && (l >= 1) && (l <= 16);
         if (c && !legal) err_m = 1'b1;
         if (legal) begin
            for (int k = 0; k < int'(l); k++) void'(mq.pop_front());
            cnt_m = cnt_m + 16'(l);
         end
         if (last_acc)
            for (int b = 7; b >= 0; b--) mq.push_back(d[b]);
      end
      @(posedge clk);
      @(negedge clk);
      check("win_data", {16'd0, win_data}, {16'd0, win_m()});
      check("win_valid", {31'd0, win_valid}, {31'd0, mq.size() >= 16});
      check("fill_level", {26'd0, fill_level}, 32'(mq.size()));
      check("underflow_err", {31'd0, underflow_err}, {31'd0, err_m});
      check("bits_consumed", {16'd0, bits_consumed}, {16'd0, cnt_m});
   endtask

   initial begin
      logic       pv, c, r, f;
      logic [7:0] pd;
      logic [4:0] l;
      int         n_cons, cycles;

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; consume = 1'b0; consume_len = '0;
      err_m = 1'b0; cnt_m = '0; last_acc = 1'b0;
      @(negedge clk);

      // Reset values
      cyc(1, 0, 0, 8'h00, 0, 0);
      cyc(1, 0, 1, 8'h77, 1, 3);
      check("rst_fill", {26'd0, fill_level}, 32'd0);
      check("rst_win", {16'd0, win_data}, 32'd0);

      // Two accepts then a 3-bit consume
      cyc(0, 0, 1, 8'hA5, 0, 0);
      cyc(0, 0, 1, 8'h3C, 0, 0);
      check("win_a53c", {16'd0, win_data}, 32'h0000_A53C);
      check("win_valid_16", {31'd0, win_valid}, 32'd1);
      cyc(0, 0, 0, 8'h00, 1, 3);
      check("win_29e0", {16'd0, win_data}, 32'h0000_29E0);
      check("fill_13", {26'd0, fill_level}, 32'd13);
      check("cnt_3", {16'd0, bits_consumed}, 32'd3);

      // Full boundary: 0xFF fills to 32, 0x11 is held off until a consume
      cyc(0, 1, 0, 8'h00, 0, 0);
      cyc(0, 0, 1, 8'h12, 0, 0);
      cyc(0, 0, 1, 8'h34, 0, 0);
      cyc(0, 0, 1, 8'h56, 0, 0);
      cyc(0, 0, 1, 8'hFF, 0, 0);
      check("fill_32", {26'd0, fill_level}, 32'd32);
      cyc(0, 0, 1, 8'h11, 0, 0);
      check("held_off", {31'd0, last_acc}, 32'd0);
      cyc(0, 0, 1, 8'h11, 1, 8);
      cycles = 0;
      while (!last_acc && cycles < 10) begin
         cyc(0, 0, 1, 8'h11, 0, 0);
         cycles++;
      end
      check("late_accept", {31'd0, last_acc}, 32'd1);
      check("order_win", {16'd0, win_data}, 32'h0000_3456);

      // Simultaneous consume 5 and accept 0x80 at fill 24
      cyc(0, 1, 0, 8'h00, 0, 0);
      cyc(0, 0, 1, 8'hC3, 0, 0);
      cyc(0, 0, 1, 8'h5A, 0, 0);
      cyc(0, 0, 1, 8'h0F, 0, 0);
      cyc(0, 0, 1, 8'h80, 1, 5);
      check("fill_27", {26'd0, fill_level}, 32'd27);
      check("win_merge", {16'd0, win_data}, 32'h0000_6B41);

      // Underflow at fill 10, sticky, cleared by flush
      cyc(0, 1, 0, 8'h00, 0, 0);
      cyc(0, 0, 1, 8'hDE, 0, 0);
      cyc(0, 0, 1, 8'hAD, 0, 0);
      cyc(0, 0, 0, 8'h00, 1, 6);
      cyc(0, 0, 0, 8'h00, 1, 4);
      check("err_set", {31'd0, underflow_err}, 32'd1);
      check("fill_10", {26'd0, fill_level}, 32'd10);
      cyc(0, 0, 0, 8'h00, 0, 0);
      check("err_sticky", {31'd0, underflow_err}, 32'd1);
      cyc(0, 1, 0, 8'h00, 0, 0);
      check("flush_err", {31'd0, underflow_err}, 32'd0);
      check("flush_keep_cnt", {16'd0, bits_consumed}, {16'd0, cnt_m});

      // Counter wrap: 4096 consumes of 16 bits
      cyc(1, 0, 0, 8'h00, 0, 0);
      n_cons = 0; cycles = 0;
      while (n_cons < 4096 && cycles < 20000) begin
         c = (mq.size() >= 16);
         cyc(0, 0, 1, 8'hFF, c, 5'd16);
         if (c) n_cons++;
         cycles++;
      end
      check("wrap_cons", 32'(n_cons), 32'd4096);
      check("wrap_cnt", {16'd0, bits_consumed}, 32'd0);
      cyc(0, 0, 1, 8'hFF, 1, 5'd16);
      cyc(1, 0, 1, 8'hFF, 1, 5'd16);
      check("midrst_fill", {26'd0, fill_level}, 32'd0);
      check("midrst_cnt", {16'd0, bits_consumed}, 32'd0);

      // Random traffic; a pending byte is held until accepted
      pv = 1'b0; pd = '0;
      repeat (3000) begin
         if (!pv && $urandom_range(0, 3) != 0) begin
            pv = 1'b1;
            pd = 8'($urandom);
         end
         r = ($urandom_range(0, 299) == 0);
         f = ($urandom_range(0, 149) == 0);
         c = ($urandom_range(0, 2) == 0);
         l = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 16));
         cyc(r, f, pv, pd, c, l);
         if (last_acc) pv = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
